// File: rtl/sr_drv_pkg.sv
// Shared FSM states, S/R excitation codes and the excitation function for the SR pattern driver.
// Build option SR_REINFORCE_EN: when defined, hold cases actively re-drive the current Q value.
package sr_drv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        PLAY  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    // Encoded as {s, r}; 2'b11 is illegal for an SR latch and has no constant here.
    localparam logic [1:0] SR_HOLD = 2'b00;
    localparam logic [1:0] SR_RST  = 2'b01;
    localparam logic [1:0] SR_SET  = 2'b10;

    function automatic logic [1:0] sr_excite(input logic q, input logic t);
        logic [1:0] exc;
        if (q == t) begin
`ifdef SR_REINFORCE_EN
            exc = t ? SR_SET : SR_RST;
`else
            exc = SR_HOLD;
`endif
        end else begin
            exc = t ? SR_SET : SR_RST;
        end
        return exc;
    endfunction

endpackage

// File: rtl/sr_fb_checker.sv
// Two-stage expected-Q pipeline that lines pushed targets up with the external FF's Q two edges later.
// Emits a one-cycle mismatch pulse per failed compare and keeps a saturating error count.
module sr_fb_checker #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_vld,
    input  logic             push_exp,
    input  logic             flush,
    input  logic             clr_cnt,
    input  logic             q_fb,
    output logic             mismatch,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic stg0_vld;
    logic stg0_exp;
    logic stg1_vld;
    logic stg1_exp;
    logic fail;

    // stg1 holds the target whose excitation the FF captured on the previous edge.
    assign fail = stg1_vld && (q_fb != stg1_exp);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stg0_vld <= 1'b0;
            stg0_exp <= 1'b0;
            stg1_vld <= 1'b0;
            stg1_exp <= 1'b0;
            mismatch <= 1'b0;
        end else if (flush) begin
            stg0_vld <= 1'b0;
            stg0_exp <= 1'b0;
            stg1_vld <= 1'b0;
            stg1_exp <= 1'b0;
            mismatch <= 1'b0;
        end else begin
            stg0_vld <= push_vld;
            stg0_exp <= push_exp;
            stg1_vld <= stg0_vld;
            stg1_exp <= stg0_exp;
            mismatch <= fail;
        end
    end

    // A flushed compare is discarded, so it never reaches the counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_cnt <= '0;
        end else if (clr_cnt) begin
            err_cnt <= '0;
        end else if (fail && !flush && (err_cnt != CNT_MAX)) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sr_ff_pattern_driver.sv
// Plays a PAT_W-bit target pattern MSB first as legal S/R excitations and self-checks the driven FF's Q.
// Build option SR_REINFORCE_EN selects active reinforcement of hold cases instead of 00.
module sr_ff_pattern_driver
    import sr_drv_pkg::*;
#(
    parameter int PAT_W = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             loop,
    input  logic [PAT_W-1:0] pattern,
    input  logic             q_fb,
    output logic             s,
    output logic             r,
    output logic             busy,
    output logic             done,
    output logic             mismatch,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int               IDX_W    = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAT_W - 1);

    state_t             state;
    state_t             state_nxt;
    logic [PAT_W-1:0]   pat_q;
    logic [PAT_W-1:0]   pat_nxt;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   idx_nxt;
    logic               drain_last;
    logic               drain_nxt;
    logic               model_q;
    logic               model_nxt;
    logic [1:0]         sr_q;
    logic [1:0]         sr_nxt;
    logic               done_q;
    logic               done_nxt;

    logic               play_go;
    logic               play_t;
    logic               push_vld;
    logic               push_exp;
    logic               flush;
    logic               clr_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            pat_q      <= '0;
            idx        <= '0;
            drain_last <= 1'b0;
            model_q    <= 1'b0;
            sr_q       <= SR_HOLD;
            done_q     <= 1'b0;
        end else begin
            state      <= state_nxt;
            pat_q      <= pat_nxt;
            idx        <= idx_nxt;
            drain_last <= drain_nxt;
            model_q    <= model_nxt;
            sr_q       <= sr_nxt;
            done_q     <= done_nxt;
        end
    end

    // Outputs are computed for the state being entered so s/r are registered alongside it.
    always_comb begin
        state_nxt = state;
        pat_nxt   = pat_q;
        idx_nxt   = idx;
        drain_nxt = drain_last;
        model_nxt = model_q;
        sr_nxt    = SR_HOLD;
        done_nxt  = 1'b0;
        play_go   = 1'b0;
        play_t    = 1'b0;
        push_vld  = 1'b0;
        push_exp  = 1'b0;
        flush     = 1'b0;
        clr_cnt   = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = CLEAR;
                    pat_nxt   = pattern;
                    model_nxt = 1'b0;
                    sr_nxt    = SR_RST;
                    push_vld  = 1'b1;
                    push_exp  = 1'b0;
                    clr_cnt   = 1'b1;
                end
            end
            CLEAR: begin
                state_nxt = PLAY;
                idx_nxt   = IDX_LAST;
                play_go   = 1'b1;
                play_t    = pat_q[PAT_W-1];
            end
            PLAY: begin
                if (idx != '0) begin
                    idx_nxt = idx - 1'b1;
                    play_go = 1'b1;
                    play_t  = pat_q[idx_nxt];
                end else if (loop) begin
                    // Seamless replay: model q carries over from the last bit of the previous pass.
                    pat_nxt = pattern;
                    idx_nxt = IDX_LAST;
                    play_go = 1'b1;
                    play_t  = pattern[PAT_W-1];
                end else begin
                    state_nxt = DRAIN;
                    drain_nxt = 1'b0;
                end
            end
            DRAIN: begin
                if (drain_last) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end else begin
                    drain_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (play_go) begin
            sr_nxt    = sr_excite(model_q, play_t);
            model_nxt = play_t;
            push_vld  = 1'b1;
            push_exp  = play_t;
        end

        if (abort) begin
            state_nxt = IDLE;
            pat_nxt   = pat_q;
            idx_nxt   = idx;
            model_nxt = model_q;
            sr_nxt    = SR_HOLD;
            done_nxt  = 1'b0;
            push_vld  = 1'b0;
            push_exp  = 1'b0;
            flush     = 1'b1;
            clr_cnt   = 1'b0;
        end
    end

    sr_fb_checker #(
        .CNT_W(CNT_W)
    ) u_checker (
        .clk      (clk),
        .reset    (reset),
        .push_vld (push_vld),
        .push_exp (push_exp),
        .flush    (flush),
        .clr_cnt  (clr_cnt),
        .q_fb     (q_fb),
        .mismatch (mismatch),
        .err_cnt  (err_cnt)
    );

    assign s    = sr_q[1];
    assign r    = sr_q[0];
    assign busy = (state != IDLE);
    assign done = done_q;

endmodule

// File: tb/tb_sr_ff_pattern_driver.sv
// Bench for sr_ff_pattern_driver: random and directed patterns against a queue-based reference model.
// Honours SR_REINFORCE_EN so the same bench covers both builds.
module tb_sr_ff_pattern_driver;

    localparam int PAT_W = 8;

`ifdef SR_REINFORCE_EN
    localparam bit REINF = 1'b1;
`else
    localparam bit REINF = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             abort;
    logic             loop;
    logic [PAT_W-1:0] pattern;
    logic             q_fb;

    logic             s, r, busy, done, mismatch;
    logic [3:0]       err_cnt;
    logic             s3, r3, busy3, done3, mismatch3;
    logic [2:0]       err_cnt3;

    int n_checks = 0;
    int n_fail   = 0;
    int fb_mode  = 0;   // 0 ideal SR FF, 1 stuck at 0, 2 stuck at 1
    logic ff_q   = 1'b0;

    logic [1:0] exp_sr[$];
    logic       exp_q[$];

    always #5 clk = ~clk;

    sr_ff_pattern_driver #(.PAT_W(PAT_W), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .loop(loop),
        .pattern(pattern), .q_fb(q_fb), .s(s), .r(r), .busy(busy), .done(done),
        .mismatch(mismatch), .err_cnt(err_cnt)
    );

    sr_ff_pattern_driver #(.PAT_W(PAT_W), .CNT_W(3)) dut_sat (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .loop(loop),
        .pattern(pattern), .q_fb(q_fb), .s(s3), .r(r3), .busy(busy3), .done(done3),
        .mismatch(mismatch3), .err_cnt(err_cnt3)
    );

    // Ideal SR flip-flop driven by the DUT.
    always @(posedge clk) begin
        if (s && !r)      ff_q <= 1'b1;
        else if (r && !s) ff_q <= 1'b0;
    end

    always_comb begin
        case (fb_mode)
            1:       q_fb = 1'b0;
            2:       q_fb = 1'b1;
            default: q_fb = ff_q;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected excitations and expected Q per pushed check, from the plain excitation table.
    task automatic build_expect(input logic [PAT_W-1:0] p1, input logic [PAT_W-1:0] p2,
                                input int passes);
        logic q, t, es, er;
        logic [PAT_W-1:0] p;
        exp_sr.delete();
        exp_q.delete();
        exp_sr.push_back(2'b01);
        exp_q.push_back(1'b0);
        q = 1'b0;
        for (int pass = 0; pass < passes; pass++) begin
            p = (pass == 0) ? p1 : p2;
            for (int b = PAT_W - 1; b >= 0; b--) begin
                t  = p[b];
                es = (t && !q) || (REINF && t && q);
                er = (!t && q) || (REINF && !t && !q);
                exp_sr.push_back({es, er});
                exp_q.push_back(t);
                q = t;
            end
        end
        exp_sr.push_back(2'b00);
        exp_sr.push_back(2'b00);
    endtask

    task automatic run_seq(input logic [PAT_W-1:0] p1, input logic [PAT_W-1:0] p2,
                           input int passes, input int mode, input string name);
        int len, exp_err, mm, mm3;
        build_expect(p1, p2, passes);
        fb_mode = mode;
        exp_err = 0;
        if (mode != 0)
            foreach (exp_q[j]) if (exp_q[j] != (mode == 2)) exp_err++;
        len = exp_sr.size();
        mm  = 0;
        mm3 = 0;
        @(negedge clk);
        pattern = p1;
        start   = 1'b1;
        loop    = (passes > 1);
        for (int k = 0; k < len; k++) begin
            tick();
            start = 1'b0;
            if (k == 0) pattern = p2;
            if (k >= 1 + (passes - 1) * PAT_W) loop = 1'b0;
            mm  += int'(mismatch);
            mm3 += int'(mismatch3);
            n_checks++;
            if ({s, r} !== exp_sr[k]) begin
                n_fail++;
                $display("FAIL %s sr cycle %0d: got %b%b want %b", name, k, s, r, exp_sr[k]);
            end
            n_checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL %s busy/done cycle %0d: got %b/%b want 1/0", name, k, busy, done);
            end
        end
        tick();
        mm  += int'(mismatch);
        mm3 += int'(mismatch3);
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || {s, r} !== 2'b00) begin
            n_fail++;
            $display("FAIL %s done edge: got done=%b busy=%b sr=%b%b want 1 0 00", name, done, busy, s, r);
        end
        tick();
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s done width: got %b want 0", name, done);
        end
        n_checks++;
        if (mm != exp_err) begin
            n_fail++;
            $display("FAIL %s mismatch pulses: got %0d want %0d", name, mm, exp_err);
        end
        n_checks++;
        if (int'(err_cnt) != ((exp_err > 15) ? 15 : exp_err)) begin
            n_fail++;
            $display("FAIL %s err_cnt: got %0d want %0d", name, err_cnt, (exp_err > 15) ? 15 : exp_err);
        end
        n_checks++;
        if (int'(err_cnt3) != ((exp_err > 7) ? 7 : exp_err) || mm3 != exp_err) begin
            n_fail++;
            $display("FAIL %s err_cnt3: got %0d (%0d pulses) want %0d (%0d pulses)", name, err_cnt3, mm3,
                     (exp_err > 7) ? 7 : exp_err, exp_err);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; abort = 1'b0; loop = 1'b0; pattern = '0; fb_mode = 0;
        #12;
        n_checks++;
        if ({s, r, busy, done, mismatch} !== 5'b0 || err_cnt !== 4'd0 || err_cnt3 !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_state: got s r busy done mm=%b%b%b%b%b err=%0d want all 0",
                     s, r, busy, done, mismatch, err_cnt);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset_mid_play();
        fb_mode = 1;
        @(negedge clk);
        pattern = 8'hFF;
        start   = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            start = 1'b0;
        end
        n_checks++;
        if (busy !== 1'b1 || err_cnt == 4'd0) begin
            n_fail++;
            $display("FAIL reset_mid_setup: got busy=%b err=%0d want busy 1 err nonzero", busy, err_cnt);
        end
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if ({s, r, busy, done, mismatch} !== 5'b0 || err_cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_mid_play: got s r busy done mm=%b%b%b%b%b err=%0d want all 0",
                     s, r, busy, done, mismatch, err_cnt);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_abort();
        int exp_err, sum_done;
        build_expect(8'hFF, 8'hFF, 1);
        fb_mode = 1;
        @(negedge clk);
        pattern = 8'hFF;
        start   = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            start = 1'b0;
        end
        // abort and start together, sampled at edge E5 while in PLAY
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        exp_err = 0;
        for (int j = 0; j + 2 < 5; j++) if (exp_q[j] != 1'b0) exp_err++;
        n_checks++;
        if (busy !== 1'b0 || {s, r} !== 2'b00 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_next: got busy=%b sr=%b%b done=%b want 0 00 0", busy, s, r, done);
        end
        sum_done = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            sum_done += int'(done) + int'(busy) + int'(mismatch);
        end
        n_checks++;
        if (sum_done != 0) begin
            n_fail++;
            $display("FAIL abort_idle: got %0d done/busy/mismatch samples want 0", sum_done);
        end
        n_checks++;
        if (int'(err_cnt) != exp_err) begin
            n_fail++;
            $display("FAIL abort_err_hold: got %0d want %0d", err_cnt, exp_err);
        end
    endtask

    task automatic test_normal();
        run_seq(8'b1011_0010, 8'h3C, 1, 0, "normal");
    endtask

    task automatic test_stuck0();
        run_seq(8'hFF, 8'h00, 1, 1, "stuck0");
    endtask

    task automatic test_saturation();
        run_seq(8'h00, 8'hFF, 1, 2, "saturate");
    endtask

    task automatic test_loop();
        run_seq(8'hA5, 8'hA5, 2, 0, "loop_a5");
        run_seq(8'h96, 8'h5B, 3, 0, "loop_reload");
    endtask

    task automatic test_reinforce();
        run_seq(8'b1100_0011, 8'h00, 1, 0, "reinforce");
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            run_seq(PAT_W'($urandom), PAT_W'($urandom), int'($urandom_range(1, 2)),
                    int'($urandom_range(0, 2)), $sformatf("rand%0d", i));
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_stuck0();
        test_saturation();
        test_loop();
        test_reinforce();
        test_abort();
        test_reset_mid_play();
        test_normal();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sr_ff_pattern_driver.md
Name: sr_ff_pattern_driver

Overview:
- Transmit-side companion of the course's SR flip-flop.
- Serialises a PAT_W-bit target pattern into legal S/R excitation pairs (never 11) that drive an external SR flip-flop.
- Reads the flip-flop's Q back and counts any mismatch against the expected sequence.
- Sits in the W7 lab harness as stimulus generator and self-checker for the SR FF under test.

Parameters:
- PAT_W, 8, pattern length in bits; played MSB first.
- CNT_W, 4, width of the saturating error counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  begin playback; sampled only in IDLE.
- abort  input  1  stop playback at once.
- loop  input  1  at end of PLAY, replay the pattern without CLEAR.
- pattern  input  PAT_W  target Q sequence; captured on start and on each loop reload.
- q_fb  input  1  Q of the driven flip-flop.
- s  output  1  set excitation, registered.
- r  output  1  reset excitation, registered.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse when playback completes.
- mismatch  output  1  one-cycle pulse per failed check.
- err_cnt  output  CNT_W  saturating mismatch count.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE. s, r, busy, done, mismatch=0. err_cnt=0. Model q=0. Check pipeline cleared.
- FSM: IDLE -> CLEAR -> PLAY -> DRAIN -> IDLE.
- IDLE:
  - start=1 at edge E0 captures pattern, clears err_cnt, and enters CLEAR.
  - start while busy is ignored.
- CLEAR (1 cycle): s,r=01. Model q=0. Pushes expected 0 into the check pipeline.
- PLAY (PAT_W cycles, bit index PAT_W-1 down to 0):
  - Target t = pattern bit; excitation from model q:
    - q0 t0 -> 00
    - q0 t1 -> 10
    - q1 t0 -> 01
    - q1 t1 -> 00
  - Model q <= t. Expected t is pushed into the check pipeline.
- End of PLAY:
  - loop=1: recapture pattern and restart PLAY at the MSB on the next cycle, with no gap and no CLEAR.
  - loop=0: enter DRAIN.
- DRAIN (2 cycles): s,r=00, nothing new pushed.
- After DRAIN: state=IDLE and done=1 for one cycle.
- Timing with start sampled at E0:
  - CLEAR after E0; PLAY after E1..E(PAT_W).
  - DRAIN after E(PAT_W+1) and E(PAT_W+2).
  - done registered at E(PAT_W+3).
  - busy is high from E0 through E(PAT_W+2).
- Check latency: the s/r registered at edge Ek is captured by the external FF at Ek+1, and q_fb is compared at Ek+2. Implemented as a 2-stage {valid, expected} pipeline.
- On a valid compare with q_fb != expected: mismatch=1 for one cycle and err_cnt increments, saturating at 2^CNT_W-1.
- abort=1 (highest priority, beats start and loop in the same cycle):
  - Next state IDLE, s,r=00, pipeline flushed, no done pulse.
  - err_cnt is held.
- Reset mid-operation returns everything to reset values immediately.
- s=r=1 is never driven, in any state or configuration.

Optional Feature:
- Macro: SR_REINFORCE_EN.
- Defined: hold cases are actively reinforced.
  - q0 t0 -> 01
  - q1 t1 -> 10
- Undefined: hold cases drive 00.
- All other behaviour, including CLEAR and DRAIN, is identical in both builds.

Decomposition:
- Package sr_drv_pkg:
  - State enum (IDLE, CLEAR, PLAY, DRAIN).
  - Excitation constants SR_HOLD=2'b00, SR_RST=2'b01, SR_SET=2'b10.
  - Function sr_excite(q, t) returning the 2-bit excitation.
- Sub-module sr_fb_checker: 2-stage expected/valid pipeline, comparator, mismatch pulse, saturating err_cnt, flush input.

Test Plan:
- Reset and abort: reset=0 asserted mid-PLAY -> s, r, busy, done, mismatch, err_cnt all 0 within the same cycle. Separately, abort and start both high in the same PLAY cycle -> IDLE next cycle, s,r=00, no done.
- Normal playback: PAT_W=8, pattern=8'b1011_0010, ideal FF model on q_fb, start at E0:
  - s,r sequence 01 | 10,01,10,00,01,00,10,01, then 00,00.
  - done at E11; err_cnt=0; s=r=1 never seen.
- Stuck-at-0 feedback: q_fb tied 0, pattern=8'hFF -> 8 mismatch pulses, final err_cnt=8.
- Saturation: CNT_W=3, q_fb tied 1, pattern=8'h00 -> 9 failed checks (CLEAR plus 8 bits), err_cnt saturates at 7.
- Loop: loop=1, pattern=8'hA5:
  - 16 consecutive PLAY cycles with no CLEAR between passes; at the second pass's first bit (1) the model q is already 1 from the first pass's last bit, so s,r=00.
  - Drop loop during the second pass -> DRAIN, then done.
- Macro: with SR_REINFORCE_EN defined and pattern=8'b1100_0011 -> hold bits drive 10 or 01 (never 00 or 11) and err_cnt=0.
